gcd_arbiter: RTL and testbench
==============================

# gcd_arbiter

Round-robin front-end that shares one `gcd_rtl` subtractive GCD engine among `N_REQ` independent requesters. It sequences the engine through load, compute and acknowledge, and routes each result back to the requester that issued it. One job is in flight at a time. It sits between the requester ports and the single engine instance, and also keeps a completed-job counter.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `W`, 16: operand/result width; must match the engine.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high. It is shared with the engine instance.
- `req_val` in N_REQ: requester i has a valid job.
- `req_ready` out N_REQ: one-hot. Job i is accepted in any cycle where `req_val[i] & req_ready[i]`.
- `req_a`, `req_b` in N_REQ*W: flattened operands; slice i is `[i*W +: W]`.
- `resp_val` out N_REQ: one-hot. A result is pending for requester i.
- `resp_rdy` in N_REQ: requester i takes its result.
- `resp_data` out W: result of the pending job.
- `jobs_done` out 16: count of completed responses, wraps at 2^16.
- `gcd_operands_val` out 1: drives the engine's `operands_val`.
- `gcd_a`, `gcd_b` out W: drive the engine's `A_in` and `B_in`.
- `gcd_valid` in 1: the engine's `gcd_valid`.
- `gcd_out` in W: the engine's `gcd_out`.
- `gcd_ack` out 1: drives the engine's `ack_rcvd`.

## Operation
- The FSM has four states: ARB, LOAD, WAIT and RESP.
- **ARB**
  - If any `req_val` is high, the grant is the first requester at or after `rr_ptr`, searching in increasing index with wrap.
  - `req_ready[g]` is asserted combinationally in the same cycle.
  - The operands are captured into `op_a`/`op_b` and `g` into `grant_id`. Next state is LOAD.
  - With no `req_val` high, the FSM stays in ARB.
- **LOAD**
  - `gcd_operands_val` = 1 for exactly this cycle. Next state is WAIT.
  - `gcd_a`/`gcd_b` are driven from `op_a`/`op_b` in all states.
  - The engine reloads its inputs every cycle while idle, so the captured values are loaded on the LOAD edge.
- **WAIT**
  - `gcd_ack` = `gcd_valid`, combinationally.
  - On `gcd_valid`, `gcd_out` is captured into `result`. Next state is RESP.
  - The engine returns to idle on the following edge.
- **RESP**
  - `resp_val[grant_id]` = 1 and `resp_data` = `result`.
  - On `resp_rdy[grant_id]`: `jobs_done` increments, `rr_ptr` = `grant_id`+1 (mod N_REQ), next state is ARB.
  - `resp_rdy` on other indices is ignored.
- The engine's `ready` output is not used. Engine state is tracked solely by this FSM.
- Operand semantics follow the engine:
  - gcd(x,0)=x
  - gcd(0,y)=y
  - gcd(0,0)=0
- There is no timeout. The engine worst case is about 2^W cycles, e.g. (65535,1).
- New requests arriving during LOAD/WAIT/RESP are held off (`req_ready`=0). Requesters must keep `req_val` and their operands stable until accepted.

## Timing
- Reset values:
  - state = ARB, `rr_ptr` = 0, `jobs_done` = 0.
  - `req_ready`, `resp_val`, `gcd_operands_val` and `gcd_ack` are all 0 in the cycle after reset. `req_ready` may assert combinationally once `req_val` is high.
  - `op_a`, `op_b`, `result` = 0.
- Reset mid-job: the job is dropped silently with no response, and the engine resets with it.
- Cycle numbering for a job accepted in cycle 0 (the ARB cycle):
  - Cycle 1: LOAD.
  - Cycle 2: engine busy, doing one subtract or swap per cycle, plus one cycle to detect B==0.
  - If the engine spends K busy cycles, `gcd_valid`/`gcd_ack` occur in cycle 2+K and `resp_val` in cycle 3+K.
- Minimum turnaround: acceptance of the next job is possible in the cycle after `resp_rdy` is sampled high.
- `resp_rdy` held high in RESP completes the handshake in 1 cycle. RESP holds indefinitely otherwise.
- A requester may re-assert `req_val` while its response is pending; it is not served until RESP exits.

## Structure
- Shared package `gcd_pkg`: state enum {ARB, LOAD, WAIT, RESP} and default width `GCD_W`=16.
- One sub-module, `rr_pick`: combinational round-robin priority encoder taking `req_val` and `rr_ptr` and producing a one-hot grant plus its index.
- The engine is instantiated by the parent, not inside this block.

## Test plan
- **Single job, zero B:** after reset, req 0 presents (12,0) at cycle 0 with `resp_rdy` high. Require `req_ready[0]` in cycle 0, `resp_val[0]` in cycle 4, `resp_data`=12, `jobs_done`=1.
- **Full computation:** req 1 presents (48,18). Require `gcd_operands_val` only in cycle 1, K=9, `resp_val[1]` in cycle 12 with data 6, and `gcd_ack` pulsed exactly once in cycle 11.
- **Round robin:** all 4 requesters held valid, with 5 jobs completed. Require grant order 0,1,2,3,0, each `resp_val` on the matching index only.
- **Backpressure:** hold `resp_rdy[2]`=0 for 20 cycles with other `req_val` high. Require `resp_val[2]` and `resp_data` stable and no `req_ready` asserted. `resp_rdy[3]`=1 meanwhile has no effect.
- **Edge operands:** (0,7) gives 7, (0,0) gives 0, and (65535,1) gives 1 with latency above 65535 cycles.
- **Reset mid-job:** assert `reset` in WAIT. Require no `resp_val`, `jobs_done`=0, and a new job afterwards granted starting from index 0.

Source files
------------

// File: rtl/gcd_pkg.sv
// -----------------------------------------------------------------------------
// gcd_pkg
// Shared definitions for the GCD arbiter slice: the arbiter FSM state
// encoding and the default operand/result width of the GCD engine.
// -----------------------------------------------------------------------------
package gcd_pkg;

  // Default operand/result width; must match the shared gcd_rtl engine.
  localparam int GCD_W  = 16;

  // Width of the completed-job counter (wraps naturally).
  localparam int JOBS_W = 16;

  // Arbiter sequencing: pick a requester, load the engine, wait for the
  // result, then hold the response until the owner takes it.
  typedef enum logic [1:0] {
    ARB  = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/gcd_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority encoder. Grants the first requester at
// or after ptr_i, searching upward and wrapping to index 0.
//
// Ports:
//   req_i   [N]  request vector
//   ptr_i   [IW] highest-priority index this cycle (must be < N)
//   any_o        at least one request is present
//   grant_o [N]  one-hot grant (all zero when any_o is low)
//   idx_o   [IW] index of the granted requester
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          any_o,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    // NOTE: every output gets a default before the search loops; without it a
    // path that assigns nothing would infer a latch.
    any_o   = 1'b0;
    grant_o = '0;
    idx_o   = '0;

    // First pass: indices at or above the pointer.
    for (int i = 0; i < N; i++) begin
      if (!any_o && req_i[i] && (IW'(i) >= ptr_i)) begin
        any_o      = 1'b1;
        grant_o[i] = 1'b1;
        idx_o      = IW'(i);
      end
    end

    // Second pass covers the wrap: only reached when nothing at/after the
    // pointer is requesting, so the lowest requesting index wins.
    for (int i = 0; i < N; i++) begin
      if (!any_o && req_i[i]) begin
        any_o      = 1'b1;
        grant_o[i] = 1'b1;
        idx_o      = IW'(i);
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// -----------------------------------------------------------------------------
// gcd_arbiter
// Round-robin front-end sharing one subtractive GCD engine (gcd_rtl, owned by
// the parent) among N_REQ requesters. One job in flight at a time: the FSM
// accepts a job (ARB), pulses the engine load (LOAD), waits for the result and
// acknowledges it (WAIT), then presents the result to the issuing requester
// until taken (RESP). Also counts completed responses.
//
// Ports:
//   clk, reset               clock; synchronous active-high reset (shared
//                            with the engine instance)
//   req_val  [N_REQ]         requester i has a valid job
//   req_ready[N_REQ]         one-hot acceptance, combinational in ARB
//   req_a/req_b [N_REQ*W]    flattened operands, slice i = [i*W +: W]
//   resp_val [N_REQ]         one-hot: result pending for requester i
//   resp_rdy [N_REQ]         requester i takes its result
//   resp_data[W]             pending result
//   jobs_done[16]            completed-response counter, wraps
//   gcd_operands_val         engine operands_val (one cycle, in LOAD)
//   gcd_a, gcd_b [W]         engine A_in / B_in, always the captured operands
//   gcd_valid, gcd_out [W]   engine result handshake
//   gcd_ack                  engine ack_rcvd, = gcd_valid while in WAIT
// -----------------------------------------------------------------------------
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = GCD_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_val,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*W-1:0]   req_a,
  input  logic [N_REQ*W-1:0]   req_b,
  output logic [N_REQ-1:0]     resp_val,
  input  logic [N_REQ-1:0]     resp_rdy,
  output logic [W-1:0]         resp_data,
  output logic [JOBS_W-1:0]    jobs_done,
  output logic                 gcd_operands_val,
  output logic [W-1:0]         gcd_a,
  output logic [W-1:0]         gcd_b,
  input  logic                 gcd_valid,
  input  logic [W-1:0]         gcd_out,
  output logic                 gcd_ack
);

  localparam int IW = $clog2(N_REQ);

  state_e               state_q;
  logic [IW-1:0]        rr_ptr_q;
  logic [IW-1:0]        grant_id_q;
  logic [W-1:0]         op_a_q;
  logic [W-1:0]         op_b_q;
  logic [W-1:0]         result_q;
  logic [JOBS_W-1:0]    jobs_done_q;
  logic                 load_q;
  logic [N_REQ-1:0]     resp_val_q;

  logic                 pick_any;
  logic [N_REQ-1:0]     pick_grant;
  logic [IW-1:0]        pick_idx;
  logic [W-1:0]         sel_a;
  logic [W-1:0]         sel_b;
  logic [IW-1:0]        rr_ptr_d;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req_i   (req_val),
    .ptr_i   (rr_ptr_q),
    .any_o   (pick_any),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_grant[i]) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  // Priority moves to the requester just after the one that was served.
  assign rr_ptr_d = (grant_id_q == IW'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  // NOTE: reset is sampled on the clock edge (synchronous), so it lives inside
  // the clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      result_q    <= '0;
      jobs_done_q <= '0;
      load_q      <= 1'b0;
      resp_val_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge value of the others, independent of statement order.
      case (state_q)
        ARB: begin
          if (pick_any) begin
            op_a_q     <= sel_a;
            op_b_q     <= sel_b;
            grant_id_q <= pick_idx;
            load_q     <= 1'b1;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          // The idle engine has latched op_a/op_b on this edge.
          load_q  <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (gcd_valid) begin
            result_q   <= gcd_out;
            resp_val_q <= N_REQ'(1) << grant_id_q;
            state_q    <= RESP;
          end
        end
        RESP: begin
          // Only the owner's ready counts; other resp_rdy bits are ignored.
          if (resp_rdy[grant_id_q]) begin
            jobs_done_q <= jobs_done_q + 16'd1;
            rr_ptr_q    <= rr_ptr_d;
            resp_val_q  <= '0;
            state_q     <= ARB;
          end
        end
        default: begin
          state_q <= ARB;
        end
      endcase
    end
  end

  // Acceptance and engine acknowledge are combinational so a job is taken
  // and a result released in the same cycle they are offered.
  assign req_ready        = (state_q == ARB) ? pick_grant : '0;
  assign gcd_ack          = (state_q == WAIT) && gcd_valid;

  assign gcd_operands_val = load_q;
  assign gcd_a            = op_a_q;
  assign gcd_b            = op_b_q;
  assign resp_val         = resp_val_q;
  assign resp_data        = result_q;
  assign jobs_done        = jobs_done_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gcd_arbiter
// Directed bench for gcd_arbiter. A behavioural subtractive GCD engine stands
// in for gcd_rtl: idle reloads A/B every cycle and starts on operands_val;
// busy swaps when A<B, subtracts when B!=0, otherwise finishes; done holds
// gcd_valid until ack.
// -----------------------------------------------------------------------------
module tb_gcd_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic             clk;
  logic             reset;
  logic [N-1:0]     req_val;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N-1:0]     resp_val;
  logic [N-1:0]     resp_rdy;
  logic [W-1:0]     resp_data;
  logic [15:0]      jobs_done;
  logic             gcd_operands_val;
  logic [W-1:0]     gcd_a;
  logic [W-1:0]     gcd_b;
  logic             gcd_valid;
  logic [W-1:0]     gcd_out;
  logic             gcd_ack;

  int checks = 0;
  int errors = 0;

  gcd_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_val          (req_val),
    .req_ready        (req_ready),
    .req_a            (req_a),
    .req_b            (req_b),
    .resp_val         (resp_val),
    .resp_rdy         (resp_rdy),
    .resp_data        (resp_data),
    .jobs_done        (jobs_done),
    .gcd_operands_val (gcd_operands_val),
    .gcd_a            (gcd_a),
    .gcd_b            (gcd_b),
    .gcd_valid        (gcd_valid),
    .gcd_out          (gcd_out),
    .gcd_ack          (gcd_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine model (0 idle, 1 busy, 2 done).
  logic [1:0]   e_st;
  logic [W-1:0] e_a;
  logic [W-1:0] e_b;

  always @(posedge clk) begin
    if (reset) begin
      e_st <= 2'd0;
      e_a  <= '0;
      e_b  <= '0;
    end else begin
      case (e_st)
        2'd0: begin
          e_a <= gcd_a;
          e_b <= gcd_b;
          if (gcd_operands_val) e_st <= 2'd1;
        end
        2'd1: begin
          if (e_a < e_b) begin
            e_a <= e_b;
            e_b <= e_a;
          end else if (e_b != 0) begin
            e_a <= e_a - e_b;
          end else begin
            e_st <= 2'd2;
          end
        end
        default: begin
          if (gcd_ack) e_st <= 2'd0;
        end
      endcase
    end
  end

  assign gcd_valid = (e_st == 2'd2);
  assign gcd_out   = e_a;

  task automatic do_reset();
    reset    = 1'b1;
    req_val  = '0;
    resp_rdy = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Presents one job on requester idx with resp_rdy all high and records the
  // cycle (relative to the first presented cycle) of each observed event.
  task automatic run_job(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int budget,
                         output int acc_cyc, output logic [N-1:0] acc_vec,
                         output int ld_cnt, output int ld_cyc,
                         output int ack_cnt, output int ack_cyc,
                         output int rsp_cyc, output logic [N-1:0] rsp_vec,
                         output logic [W-1:0] rsp_dat);
    acc_cyc = -1; acc_vec = '0; ld_cnt = 0; ld_cyc = -1;
    ack_cnt = 0; ack_cyc = -1; rsp_cyc = -1; rsp_vec = '0; rsp_dat = '0;
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_val[idx] = 1'b1;
    resp_rdy = '1;
    for (int c = 0; c < budget && rsp_cyc < 0; c++) begin
      @(negedge clk);
      if (acc_cyc < 0 && (req_val & req_ready) != '0) begin
        acc_cyc = c;
        acc_vec = req_ready;
      end
      if (gcd_operands_val) begin ld_cnt++; ld_cyc = c; end
      if (gcd_ack) begin ack_cnt++; ack_cyc = c; end
      if (resp_val != '0) begin
        rsp_cyc = c;
        rsp_vec = resp_val;
        rsp_dat = resp_data;
      end
      @(posedge clk);
      #1;
      if (acc_cyc >= 0) req_val[idx] = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_val = '0; resp_rdy = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    checks++; if (resp_val !== 4'b0000) begin errors++; $display("FAIL reset_resp_val got %b want 0000", resp_val); end
    checks++; if (gcd_operands_val !== 1'b0) begin errors++; $display("FAIL reset_ld got %b want 0", gcd_operands_val); end
    checks++; if (gcd_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", gcd_ack); end
    checks++; if (jobs_done !== 16'd0) begin errors++; $display("FAIL reset_jobs got %0d want 0", jobs_done); end
    checks++; if (resp_data !== 16'd0) begin errors++; $display("FAIL reset_resp_data got %0d want 0", resp_data); end
    checks++; if (gcd_a !== 16'd0 || gcd_b !== 16'd0) begin errors++; $display("FAIL reset_ops got %0d,%0d want 0,0", gcd_a, gcd_b); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_b();
    int acc, ldn, ldc, ackn, ackc, rc;
    logic [N-1:0] av, rv;
    logic [W-1:0] rd;
    run_job(0, 16'd12, 16'd0, 50, acc, av, ldn, ldc, ackn, ackc, rc, rv, rd);
    checks++; if (acc !== 0 || av !== 4'b0001) begin errors++; $display("FAIL zb_accept got cyc %0d vec %b want 0 0001", acc, av); end
    checks++; if (rc !== 4) begin errors++; $display("FAIL zb_resp_cycle got %0d want 4", rc); end
    checks++; if (rv !== 4'b0001) begin errors++; $display("FAIL zb_resp_val got %b want 0001", rv); end
    checks++; if (rd !== 16'd12) begin errors++; $display("FAIL zb_data got %0d want 12", rd); end
    checks++; if (jobs_done !== 16'd1) begin errors++; $display("FAIL zb_jobs got %0d want 1", jobs_done); end
  endtask

  task automatic test_full_compute();
    int acc, ldn, ldc, ackn, ackc, rc;
    logic [N-1:0] av, rv;
    logic [W-1:0] rd;
    run_job(1, 16'd48, 16'd18, 100, acc, av, ldn, ldc, ackn, ackc, rc, rv, rd);
    checks++; if (acc !== 0 || av !== 4'b0010) begin errors++; $display("FAIL fc_accept got cyc %0d vec %b want 0 0010", acc, av); end
    checks++; if (ldn !== 1 || ldc !== 1) begin errors++; $display("FAIL fc_load got n=%0d cyc=%0d want n=1 cyc=1", ldn, ldc); end
    checks++; if (ackn !== 1 || ackc !== 11) begin errors++; $display("FAIL fc_ack got n=%0d cyc=%0d want n=1 cyc=11", ackn, ackc); end
    checks++; if (rc !== 12 || rv !== 4'b0010) begin errors++; $display("FAIL fc_resp got cyc %0d vec %b want 12 0010", rc, rv); end
    checks++; if (rd !== 16'd6) begin errors++; $display("FAIL fc_data got %0d want 6", rd); end
    checks++; if (jobs_done !== 16'd2) begin errors++; $display("FAIL fc_jobs got %0d want 2", jobs_done); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] g_vec [5];
    logic [N-1:0] r_vec [5];
    logic [W-1:0] r_dat [5];
    logic [W-1:0] exp_dat [5];
    logic [N-1:0] exp_vec;
    int n_g, n_r;
    exp_dat = '{16'd2, 16'd4, 16'd2, 16'd4, 16'd2};
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 16'(6 * (i + 1));
      req_b[i*W +: W] = 16'd4;
    end
    req_val = '1;
    resp_rdy = '1;
    n_g = 0; n_r = 0;
    for (int c = 0; c < 400 && n_r < 5; c++) begin
      @(negedge clk);
      if (req_ready != '0 && n_g < 5) begin g_vec[n_g] = req_ready; n_g++; end
      if (resp_val != '0) begin r_vec[n_r] = resp_val; r_dat[n_r] = resp_data; n_r++; end
      @(posedge clk);
      #1;
    end
    req_val = '0;
    checks++; if (n_r !== 5 || n_g !== 5) begin errors++; $display("FAIL rr_count got grants %0d resps %0d want 5 5", n_g, n_r); end
    for (int k = 0; k < n_r && k < n_g; k++) begin
      exp_vec = 4'b0001 << (k % N);
      checks++; if (g_vec[k] !== exp_vec) begin errors++; $display("FAIL rr_grant%0d got %b want %b", k, g_vec[k], exp_vec); end
      checks++; if (r_vec[k] !== exp_vec) begin errors++; $display("FAIL rr_resp%0d got %b want %b", k, r_vec[k], exp_vec); end
      checks++; if (r_dat[k] !== exp_dat[k]) begin errors++; $display("FAIL rr_data%0d got %0d want %0d", k, r_dat[k], exp_dat[k]); end
    end
    checks++; if (jobs_done !== 16'd5) begin errors++; $display("FAIL rr_jobs got %0d want 5", jobs_done); end
  endtask

  task automatic test_backpressure();
    int acc, seen;
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 16'd9;
      req_b[i*W +: W] = 16'd3;
    end
    req_a[2*W +: W] = 16'd15;
    req_b[2*W +: W] = 16'd10;
    resp_rdy = 4'b1011;
    req_val  = 4'b0100;
    acc = 0;
    for (int c = 0; c < 20 && acc == 0; c++) begin
      @(negedge clk);
      if (req_ready[2]) acc = 1;
      @(posedge clk);
      #1;
    end
    checks++; if (acc !== 1) begin errors++; $display("FAIL bp_accept got %0d want 1", acc); end
    req_val = 4'b1011;
    seen = 0;
    for (int c = 0; c < 100 && seen == 0; c++) begin
      @(negedge clk);
      if (resp_val != '0) seen = 1;
      else begin
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_busy_ready got %b want 0000", req_ready); end
        @(posedge clk);
        #1;
      end
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL bp_resp_seen got %0d want 1", seen); end
    for (int c = 0; c < 20; c++) begin
      checks++; if (resp_val !== 4'b0100) begin errors++; $display("FAIL bp_hold_val c%0d got %b want 0100", c, resp_val); end
      checks++; if (resp_data !== 16'd5) begin errors++; $display("FAIL bp_hold_data c%0d got %0d want 5", c, resp_data); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_hold_ready c%0d got %b want 0000", c, req_ready); end
      checks++; if (jobs_done !== 16'd0) begin errors++; $display("FAIL bp_hold_jobs c%0d got %0d want 0", c, jobs_done); end
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    resp_rdy[2] = 1'b1;
    checks++; if (resp_val !== 4'b0100) begin errors++; $display("FAIL bp_release_val got %b want 0100", resp_val); end
    @(posedge clk);
    #1;
    @(negedge clk);
    // Served index was 2, so requester 3 now has priority.
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_next_grant got %b want 1000", req_ready); end
    checks++; if (jobs_done !== 16'd1) begin errors++; $display("FAIL bp_jobs got %0d want 1", jobs_done); end
    checks++; if (resp_val !== 4'b0000) begin errors++; $display("FAIL bp_after_val got %b want 0000", resp_val); end
    @(posedge clk);
    #1 req_val = '0;
  endtask

  task automatic test_edge_operands();
    int acc, ldn, ldc, ackn, ackc, rc;
    logic [N-1:0] av, rv;
    logic [W-1:0] rd;
    do_reset();
    run_job(2, 16'd0, 16'd7, 50, acc, av, ldn, ldc, ackn, ackc, rc, rv, rd);
    checks++; if (rd !== 16'd7 || rv !== 4'b0100) begin errors++; $display("FAIL edge_0_7 got %0d vec %b want 7 0100", rd, rv); end
    checks++; if (rc !== 5) begin errors++; $display("FAIL edge_0_7_cycle got %0d want 5", rc); end
    run_job(3, 16'd0, 16'd0, 50, acc, av, ldn, ldc, ackn, ackc, rc, rv, rd);
    checks++; if (rd !== 16'd0 || rv !== 4'b1000) begin errors++; $display("FAIL edge_0_0 got %0d vec %b want 0 1000", rd, rv); end
    checks++; if (rc !== 4) begin errors++; $display("FAIL edge_0_0_cycle got %0d want 4", rc); end
    run_job(0, 16'd65535, 16'd1, 70000, acc, av, ldn, ldc, ackn, ackc, rc, rv, rd);
    checks++; if (rd !== 16'd1 || rv !== 4'b0001) begin errors++; $display("FAIL edge_max_1 got %0d vec %b want 1 0001", rd, rv); end
    checks++; if (rc <= 65535) begin errors++; $display("FAIL edge_max_latency got %0d want >65535", rc); end
    checks++; if (jobs_done !== 16'd3) begin errors++; $display("FAIL edge_jobs got %0d want 3", jobs_done); end
  endtask

  task automatic test_reset_mid_job();
    int acc, ldn, ldc, ackn, ackc, rc;
    logic [N-1:0] av, rv;
    logic [W-1:0] rd;
    do_reset();
    run_job(0, 16'd12, 16'd0, 50, acc, av, ldn, ldc, ackn, ackc, rc, rv, rd);
    checks++; if (jobs_done !== 16'd1) begin errors++; $display("FAIL rm_pre_jobs got %0d want 1", jobs_done); end
    req_a[3*W +: W] = 16'd100;
    req_b[3*W +: W] = 16'd1;
    req_val = 4'b1000;
    resp_rdy = '1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rm_accept got %b want 1000", req_ready); end
    @(posedge clk);
    #1 req_val = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (gcd_ack !== 1'b0 || resp_val !== 4'b0000) begin errors++; $display("FAIL rm_in_wait got ack %b val %b want 0 0000", gcd_ack, resp_val); end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (resp_val !== 4'b0000 || jobs_done !== 16'd0 || gcd_ack !== 1'b0) begin
        errors++; $display("FAIL rm_dropped c%0d got val %b jobs %0d ack %b want 0000 0 0", c, resp_val, jobs_done, gcd_ack);
      end
    end
    @(posedge clk);
    #1 req_val = '1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_regrant got %b want 0001", req_ready); end
    @(posedge clk);
    #1 req_val = '0;
  endtask

  initial begin
    test_reset();
    test_zero_b();
    test_full_compute();
    test_round_robin();
    test_backpressure();
    test_edge_operands();
    test_reset_mid_job();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
